// File: rtl/polaris_bus_arbiter.sv
// Two-master (I-fetch, D load/store) to one-slave bus arbiter for Polaris.
// Grant is combinational over a registered ownership lock, so an uncontended
// request reaches the X-port in the same cycle; all data paths are pure muxes.
module polaris_bus_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [DW-1:0] idat_i,
  input  logic [AW-1:0] iadr_i,
  input  logic          iwe_i,
  input  logic          icyc_i,
  input  logic          istb_i,
  input  logic [1:0]    isiz_i,
  input  logic          isigned_i,
  output logic          iack_o,
  output logic [DW-1:0] idat_o,
  input  logic [DW-1:0] ddat_i,
  input  logic [AW-1:0] dadr_i,
  input  logic          dwe_i,
  input  logic          dcyc_i,
  input  logic          dstb_i,
  input  logic [1:0]    dsiz_i,
  input  logic          dsigned_i,
  output logic          dack_o,
  output logic [DW-1:0] ddat_o,
  output logic [DW-1:0] xdat_o,
  output logic [AW-1:0] xadr_o,
  output logic          xwe_o,
  output logic          xcyc_o,
  output logic          xstb_o,
  output logic [1:0]    xsiz_o,
  output logic          xsigned_o,
  input  logic          xack_i,
  input  logic [DW-1:0] xdat_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  own_t own;
  own_t g;

  // Effective grant: current owner keeps the bus while its cyc is high,
  // otherwise D wins at an arbitration point. Reset kills the grant at once.
  always_comb begin
    g = OWN_NONE;
    if (!reset_i) begin
      g = OWN_NONE;
    end else if (own == OWN_I && icyc_i) begin
      g = OWN_I;
    end else if (own == OWN_D && dcyc_i) begin
      g = OWN_D;
    end else if (dcyc_i) begin
      g = OWN_D;
    end else if (icyc_i) begin
      g = OWN_I;
    end
  end

  // Ownership lock follows the grant each cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      own <= OWN_NONE;
    end else begin
      own <= g;
    end
  end

  // Route the granted master onto the X-port and the slave response back.
  always_comb begin
    xdat_o    = '0;
    xadr_o    = '0;
    xwe_o     = 1'b0;
    xcyc_o    = 1'b0;
    xstb_o    = 1'b0;
    xsiz_o    = '0;
    xsigned_o = 1'b0;
    iack_o    = 1'b0;
    idat_o    = '0;
    dack_o    = 1'b0;
    ddat_o    = '0;
    unique case (g)
      OWN_I: begin
        xdat_o    = idat_i;
        xadr_o    = iadr_i;
        xwe_o     = iwe_i;
        xcyc_o    = icyc_i;
        xstb_o    = istb_i;
        xsiz_o    = isiz_i;
        xsigned_o = isigned_i;
        iack_o    = xack_i;
        idat_o    = xdat_i;
      end
      OWN_D: begin
        xdat_o    = ddat_i;
        xadr_o    = dadr_i;
        xwe_o     = dwe_i;
        xcyc_o    = dcyc_i;
        xstb_o    = dstb_i;
        xsiz_o    = dsiz_i;
        xsigned_o = dsigned_i;
        dack_o    = xack_i;
        ddat_o    = xdat_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural ownership model.
module tb_polaris_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [DW-1:0] idat_i = '0, ddat_i = '0, xdat_i = '0;
  logic [AW-1:0] iadr_i = '0, dadr_i = '0;
  logic          iwe_i = 0, icyc_i = 0, istb_i = 0, isigned_i = 0;
  logic          dwe_i = 0, dcyc_i = 0, dstb_i = 0, dsigned_i = 0;
  logic [1:0]    isiz_i = '0, dsiz_i = '0;
  logic          xack_i = 0;
  logic          iack_o, dack_o, xwe_o, xcyc_o, xstb_o, xsigned_o;
  logic [DW-1:0] idat_o, ddat_o, xdat_o;
  logic [AW-1:0] xadr_o;
  logic [1:0]    xsiz_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: who held the bus at the last clock edge (0 none, 1 I, 2 D).
  int mown = 0;

  polaris_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .idat_i(idat_i), .iadr_i(iadr_i), .iwe_i(iwe_i), .icyc_i(icyc_i),
    .istb_i(istb_i), .isiz_i(isiz_i), .isigned_i(isigned_i),
    .iack_o(iack_o), .idat_o(idat_o),
    .ddat_i(ddat_i), .dadr_i(dadr_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
    .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
    .dack_o(dack_o), .ddat_o(ddat_o),
    .xdat_o(xdat_o), .xadr_o(xadr_o), .xwe_o(xwe_o), .xcyc_o(xcyc_o),
    .xstb_o(xstb_o), .xsiz_o(xsiz_o), .xsigned_o(xsigned_o),
    .xack_i(xack_i), .xdat_i(xdat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Who should own the bus right now, from the arbitration rules.
  function automatic int exp_grant();
    if (!reset_i) return 0;
    if (mown == 1 && icyc_i) return 1;
    if (mown == 2 && dcyc_i) return 2;
    if (dcyc_i) return 2;
    if (icyc_i) return 1;
    return 0;
  endfunction

  // Compare every output with what the granted master implies.
  task automatic check_all(input string tag);
    int eg;
    logic [63:0] e_dat, e_adr;
    logic [1:0] e_siz;
    logic e_we, e_cyc, e_stb, e_sg;
    eg = exp_grant();
    e_dat = '0; e_adr = '0; e_siz = '0;
    e_we = 0; e_cyc = 0; e_stb = 0; e_sg = 0;
    if (eg == 1) begin
      e_dat = idat_i; e_adr = iadr_i; e_siz = isiz_i;
      e_we = iwe_i; e_cyc = icyc_i; e_stb = istb_i; e_sg = isigned_i;
    end else if (eg == 2) begin
      e_dat = ddat_i; e_adr = dadr_i; e_siz = dsiz_i;
      e_we = dwe_i; e_cyc = dcyc_i; e_stb = dstb_i; e_sg = dsigned_i;
    end
    chk({tag, ".xdat"}, xdat_o, e_dat);
    chk({tag, ".xadr"}, xadr_o, e_adr);
    chk({tag, ".xsiz"}, 64'(xsiz_o), 64'(e_siz));
    chk({tag, ".xwe"}, 64'(xwe_o), 64'(e_we));
    chk({tag, ".xcyc"}, 64'(xcyc_o), 64'(e_cyc));
    chk({tag, ".xstb"}, 64'(xstb_o), 64'(e_stb));
    chk({tag, ".xsigned"}, 64'(xsigned_o), 64'(e_sg));
    chk({tag, ".iack"}, 64'(iack_o), (eg == 1) ? 64'(xack_i) : 64'd0);
    chk({tag, ".dack"}, 64'(dack_o), (eg == 2) ? 64'(xack_i) : 64'd0);
    chk({tag, ".idat"}, idat_o, (eg == 1) ? xdat_i : 64'd0);
    chk({tag, ".ddat"}, ddat_o, (eg == 2) ? xdat_i : 64'd0);
  endtask

  // Settle, check, then advance one clock and update the model owner.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk_i);
    mown = reset_i ? exp_grant() : 0;
    #1;
  endtask

  task automatic idle_all();
    icyc_i = 0; istb_i = 0; iwe_i = 0; isigned_i = 0; isiz_i = '0;
    dcyc_i = 0; dstb_i = 0; dwe_i = 0; dsigned_i = 0; dsiz_i = '0;
    xack_i = 0;
  endtask

  initial begin
    // Reset with requests pending
    @(posedge clk_i); #1;
    reset_i = 0; mown = 0;
    icyc_i = 1; istb_i = 1; xack_i = 1; iadr_i = 64'h55AA;
    #1;
    chk("rst.xstb", 64'(xstb_o), 64'd0);
    chk("rst.xadr", xadr_o, 64'd0);
    chk("rst.iack", 64'(iack_o), 64'd0);
    chk("rst.dack", 64'(dack_o), 64'd0);
    step("rst");
    reset_i = 1;
    #1;
    chk("rst_rel.xstb", 64'(xstb_o), 64'd1);
    step("rst_rel");
    idle_all();
    step("idle");

    // I-only read
    icyc_i = 1; istb_i = 1; iadr_i = 64'h1000; isiz_i = 2'b10;
    xdat_i = 64'h13; xack_i = 1;
    #1;
    chk("iread.xadr", xadr_o, 64'h1000);
    chk("iread.xsiz", 64'(xsiz_o), 64'd2);
    chk("iread.xwe", 64'(xwe_o), 64'd0);
    chk("iread.iack", 64'(iack_o), 64'd1);
    chk("iread.idat", idat_o, 64'h13);
    chk("iread.dack", 64'(dack_o), 64'd0);
    step("iread");
    idle_all();
    step("idle2");

    // Simultaneous request from idle: D wins
    icyc_i = 1; dcyc_i = 1; dadr_i = 64'h1F00; xack_i = 1;
    #1;
    chk("simul.xadr", xadr_o, 64'h1F00);
    chk("simul.dack", 64'(dack_o), 64'd1);
    chk("simul.iack", 64'(iack_o), 64'd0);
    step("simul");
    idle_all();
    step("idle3");

    // Lock: I owns, D arrives, I keeps bus until its cyc falls
    icyc_i = 1; istb_i = 1; iadr_i = 64'h2000; dadr_i = 64'h3000;
    step("lock0");
    dcyc_i = 1; dstb_i = 1; xack_i = 1;
    #1;
    chk("lock1.xadr", xadr_o, 64'h2000);
    chk("lock1.dack", 64'(dack_o), 64'd0);
    step("lock1");
    istb_i = 0;
    #1;
    chk("lock2.xadr", xadr_o, 64'h2000);
    step("lock2");
    icyc_i = 0;
    #1;
    chk("lock3.xadr", xadr_o, 64'h3000);
    chk("lock3.dack", 64'(dack_o), 64'd1);
    step("lock3");
    idle_all();
    step("idle4");

    // D write
    dcyc_i = 1; dstb_i = 1; dwe_i = 1; ddat_i = 64'hDEADBEEFCAFEF00D;
    dsiz_i = 2'b11; dsigned_i = 1;
    #1;
    chk("dwr.xwe", 64'(xwe_o), 64'd1);
    chk("dwr.xdat", xdat_o, 64'hDEADBEEFCAFEF00D);
    chk("dwr.xsiz", 64'(xsiz_o), 64'd3);
    chk("dwr.xsigned", 64'(xsigned_o), 64'd1);
    step("dwr");

    // Reset mid-transfer, D owns
    #2;
    reset_i = 0; mown = 0;
    #1;
    chk("midrst.xcyc", 64'(xcyc_o), 64'd0);
    chk("midrst.xdat", xdat_o, 64'd0);
    chk("midrst.xwe", 64'(xwe_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1;
    dcyc_i = 0; dstb_i = 0; icyc_i = 1; istb_i = 1; iadr_i = 64'h4400;
    #1;
    chk("midrst_rel.xadr", xadr_o, 64'h4400);
    step("midrst_rel");
    idle_all();
    step("idle5");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset_i = ($urandom_range(0, 39) != 0);
      if (!reset_i) mown = 0;
      icyc_i = ($urandom_range(0, 3) != 0);
      dcyc_i = ($urandom_range(0, 2) == 0);
      istb_i = $urandom_range(0, 1);
      dstb_i = $urandom_range(0, 1);
      iwe_i = $urandom_range(0, 1);
      dwe_i = $urandom_range(0, 1);
      isiz_i = 2'($urandom_range(0, 3));
      dsiz_i = 2'($urandom_range(0, 3));
      isigned_i = $urandom_range(0, 1);
      dsigned_i = $urandom_range(0, 1);
      idat_i = {$urandom, $urandom};
      ddat_i = {$urandom, $urandom};
      iadr_i = {$urandom, $urandom};
      dadr_i = {$urandom, $urandom};
      xdat_i = {$urandom, $urandom};
      xack_i = $urandom_range(0, 1);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Two-master, one-slave bus arbiter for the Polaris CPU.
- Merges the instruction-fetch master (I-port) and the load/store master (D-port) onto a single external bus (X-port).
- The X-port feeds the byte-lane bridge and the address decoder.
- Arbitration is combinational, with a registered ownership lock, so an uncontended request reaches the slave in the same cycle.

Parameters:
- AW, 64, address width of all ports.
- DW, 64, data width of all ports.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- reset_i  in  1  reset, asynchronous, active-low (0 = reset asserted).
- idat_i  in  DW  I-master write data.
- iadr_i  in  AW  I-master address.
- iwe_i  in  1  I-master write enable.
- icyc_i  in  1  I-master cycle request; held for the whole transfer.
- istb_i  in  1  I-master strobe.
- isiz_i  in  2  I-master size: 00 byte, 01 half, 10 word, 11 dword.
- isigned_i  in  1  I-master sign-extend request.
- iack_o  out  1  I-master acknowledge.
- idat_o  out  DW  I-master read data.
- ddat_i, dadr_i, dwe_i, dcyc_i, dstb_i, dsiz_i, dsigned_i  in  D-master equivalents of the I-master inputs, same widths.
- dack_o  out  1  D-master acknowledge.
- ddat_o  out  DW  D-master read data.
- xdat_o  out  DW  slave write data.
- xadr_o  out  AW  slave address.
- xwe_o  out  1  slave write enable.
- xcyc_o  out  1  slave cycle.
- xstb_o  out  1  slave strobe.
- xsiz_o  out  2  slave size.
- xsigned_o  out  1  slave signed flag.
- xack_i  in  1  slave acknowledge.
- xdat_i  in  DW  slave read data.

Behaviour:
- Ownership register `own` has three states: NONE, I, D. While reset_i=0 it is forced asynchronously to NONE.
- Effective grant `g` (combinational):
  - If own=I and icyc_i=1, then g=I.
  - Else if own=D and dcyc_i=1, then g=D.
  - Else if dcyc_i=1, then g=D (D has fixed priority at an arbitration point).
  - Else if icyc_i=1, then g=I.
  - Else g=NONE.
- Each rising clock edge: own <= g.
- Result: the owner keeps the bus as long as its cyc stays high, and the other master is held off even across multiple strobes.
- When the owner drops cyc, a waiting master is granted in that same cycle, so handover takes zero idle cycles.
- X outputs are the fields of the granted master: dat, adr, we, cyc, stb, siz, signed.
- With g=NONE, or while reset_i=0, all X outputs are 0.
- iack_o = xack_i when g=I, else 0. dack_o = xack_i when g=D, else 0.
- While reset_i=0, both acks are 0 regardless of xack_i.
- idat_o = xdat_i when g=I, else 0. ddat_o = xdat_i when g=D, else 0.
- The non-granted master only waits: its inputs never reach the X-port and it never sees an ack.
- The arbiter has no timeout. A master holding cyc high indefinitely starves the other; this is by design.
- Reset asserted mid-transfer: the grant drops immediately and the outputs go to 0. After release, arbitration restarts from NONE.
- No data-path latency is added: address, control and data are pure muxes. The only storage is the 2-bit `own`.

Test Plan:
- Reset with requests: reset_i=0, icyc_i=istb_i=1, xack_i=1 → xstb_o=0, xadr_o=0, iack_o=0, dack_o=0. After reset_i=1 the same cycle gives xstb_o=1.
- I-only read: icyc_i=istb_i=1, iadr_i=0x1000, isiz_i=10, xdat_i=0x0000000000000013, xack_i=1 → xadr_o=0x1000, xsiz_o=10, xwe_o=0, iack_o=1, idat_o=0x13, dack_o=0.
- Simultaneous request from idle: icyc_i=dcyc_i=1, dadr_i=0x1F00, xack_i=1 → xadr_o=0x1F00, dack_o=1, iack_o=0.
- Lock: I owns for one cycle, then D raises dcyc_i while icyc_i stays 1 → xadr_o stays iadr_i and dack_o=0. In the cycle icyc_i falls → xadr_o=dadr_i.
- D write: dcyc_i=dstb_i=dwe_i=1, ddat_i=0xDEADBEEFCAFEF00D, dsiz_i=11, dsigned_i=1 → xwe_o=1, xdat_o=0xDEADBEEFCAFEF00D, xsiz_o=11, xsigned_o=1.
- Reset mid-transfer: D owns, pulse reset_i=0 between clock edges → X outputs go to 0 immediately. After release with only icyc_i=1 → I granted.
